// File: rtl/sram_port_arbiter_pkg.sv
// Shared types for the sram-like port arbiter.
// Owner IDs, access size encodings and the request bundle.
package sram_port_arbiter_pkg;

    typedef enum logic {
        OWNER_INST = 1'b0,
        OWNER_DATA = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2
    } size_e;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } mem_cmd_t;

endpackage

// File: rtl/sram_port_arbiter_fifo.sv
// In-order owner FIFO: one owner ID per accepted request.
// Ports: push/push_owner in; pop in; head/full/empty/count out.
module arb_owner_fifo
    import sram_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  owner_e                   push_owner,
    input  logic                     pop,
    output owner_e                   head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    owner_e        mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rptr];

    // Depth is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= push_owner;
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one sram-like port between the inst and data requesters.
// Ports: inst_*/data_* requester sides, mem_* shared port,
// outstanding_cnt (owner FIFO level), err_unexp_resp (sticky).
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int OUTSTANDING = 2,
    parameter int DATA_STREAK = 4
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         inst_req,
    input  logic                         inst_wr,
    input  logic [1:0]                   inst_size,
    input  logic [31:0]                  inst_addr,
    input  logic [3:0]                   inst_wstrb,
    input  logic [31:0]                  inst_wdata,
    output logic                         inst_addr_ok,
    output logic                         inst_data_ok,
    output logic [31:0]                  inst_rdata,
    input  logic                         data_req,
    input  logic                         data_wr,
    input  logic [1:0]                   data_size,
    input  logic [31:0]                  data_addr,
    input  logic [3:0]                   data_wstrb,
    input  logic [31:0]                  data_wdata,
    output logic                         data_addr_ok,
    output logic                         data_data_ok,
    output logic [31:0]                  data_rdata,
    output logic                         mem_req,
    output logic                         mem_wr,
    output logic [1:0]                   mem_size,
    output logic [31:0]                  mem_addr,
    output logic [3:0]                   mem_wstrb,
    output logic [31:0]                  mem_wdata,
    input  logic                         mem_addr_ok,
    input  logic                         mem_data_ok,
    input  logic [31:0]                  mem_rdata,
    output logic [$clog2(OUTSTANDING):0] outstanding_cnt,
    output logic                         err_unexp_resp
);

    localparam int SW = $clog2(DATA_STREAK + 1);

    mem_cmd_t      inst_cmd;
    mem_cmd_t      data_cmd;
    mem_cmd_t      sel_cmd;
    owner_e        sel;
    owner_e        lock_owner;
    owner_e        head;
    logic          sel_valid;
    logic          lock;
    logic          full;
    logic          empty;
    logic          grant;
    logic          resp_ok;
    logic          force_inst;
    logic [SW-1:0] streak;

    assign inst_cmd = '{inst_wr, inst_size, inst_addr,
                        inst_wstrb, inst_wdata};
    assign data_cmd = '{data_wr, data_size, data_addr,
                        data_wstrb, data_wdata};

    assign force_inst = inst_req & (streak == SW'(DATA_STREAK));

    // A pending handshake keeps its owner regardless of priority.
    always_comb begin
        sel       = OWNER_DATA;
        sel_valid = 1'b0;
        priority case (1'b1)
            lock: begin
                sel       = lock_owner;
                sel_valid = (lock_owner == OWNER_DATA) ? data_req
                                                       : inst_req;
            end
            (data_req && !force_inst): begin
                sel       = OWNER_DATA;
                sel_valid = 1'b1;
            end
            inst_req: begin
                sel       = OWNER_INST;
                sel_valid = 1'b1;
            end
            default: ;
        endcase
    end

    assign sel_cmd   = (sel == OWNER_DATA) ? data_cmd : inst_cmd;
    assign mem_wr    = sel_cmd.wr;
    assign mem_size  = sel_cmd.size;
    assign mem_addr  = sel_cmd.addr;
    assign mem_wstrb = sel_cmd.wstrb;
    assign mem_wdata = sel_cmd.wdata;

    // Full blocks the grant even when a pop lands this cycle.
    assign mem_req = sel_valid & ~full;
    assign grant   = mem_req & mem_addr_ok;

    assign inst_addr_ok = grant & (sel == OWNER_INST);
    assign data_addr_ok = grant & (sel == OWNER_DATA);

    assign resp_ok      = mem_data_ok & ~empty;
    assign inst_data_ok = resp_ok & (head == OWNER_INST);
    assign data_data_ok = resp_ok & (head == OWNER_DATA);
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            lock       <= 1'b0;
            lock_owner <= OWNER_INST;
        end else if (mem_req) begin
            lock       <= ~mem_addr_ok;
            lock_owner <= sel;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn || !inst_req) begin
            streak <= '0;
        end else if (grant) begin
            if (sel == OWNER_INST)
                streak <= '0;
            else if (streak != SW'(DATA_STREAK))
                streak <= streak + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn)
            err_unexp_resp <= 1'b0;
        else if (mem_data_ok && empty)
            err_unexp_resp <= 1'b1;
    end

    arb_owner_fifo #(
        .DEPTH(OUTSTANDING)
    ) u_fifo (
        .clk        (clk),
        .resetn     (resetn),
        .push       (grant),
        .push_owner (sel),
        .pop        (mem_data_ok),
        .head       (head),
        .full       (full),
        .empty      (empty),
        .count      (outstanding_cnt)
    );

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter.
// Owner scoreboard: expected owner pushed at grant, popped at response.
module tb_sram_port_arbiter;

    localparam int OUTSTANDING = 2;
    localparam int DATA_STREAK = 4;
    localparam logic [31:0] IADDR = 32'h0000_1000;
    localparam logic [31:0] DADDR = 32'h0000_2000;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata, inst_rdata;
    logic [3:0]  inst_wstrb;
    logic        inst_addr_ok, inst_data_ok;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok, data_data_ok;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        mem_addr_ok, mem_data_ok;
    logic [$clog2(OUTSTANDING):0] outstanding_cnt;
    logic        err_unexp_resp;

    int   pass_cnt  = 0;
    int   total_cnt = 0;
    logic exp_q[$];
    logic e;

    always #5 clk = ~clk;

    sram_port_arbiter #(
        .OUTSTANDING(OUTSTANDING),
        .DATA_STREAK(DATA_STREAK)
    ) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_wr(inst_wr),
        .inst_size(inst_size), .inst_addr(inst_addr),
        .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr),
        .data_size(data_size), .data_addr(data_addr),
        .data_wstrb(data_wstrb), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
        .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
        .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
        .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
        .outstanding_cnt(outstanding_cnt),
        .err_unexp_resp(err_unexp_resp)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        inst_req    = 1'b0;
        data_req    = 1'b0;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        mem_rdata   = 32'h0;
    endtask

    task automatic test_reset();
        idle();
        resetn = 1'b0;
        step();
        step();
        total_cnt++;
        if (mem_req !== 1'b0)
            $display("FAIL reset_mem_req: got %b want 0", mem_req);
        else pass_cnt++;
        total_cnt++;
        if (outstanding_cnt !== 2'd0)
            $display("FAIL reset_cnt: got %0d want 0", outstanding_cnt);
        else pass_cnt++;
        total_cnt++;
        if (err_unexp_resp !== 1'b0)
            $display("FAIL reset_err: got %b want 0", err_unexp_resp);
        else pass_cnt++;
        total_cnt++;
        if ({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}
            !== 4'b0)
            $display("FAIL reset_oks: got %b want 0000",
                {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok});
        else pass_cnt++;
        resetn = 1'b1;
        step();
    endtask

    task automatic test_priority();
        inst_req    = 1'b1;
        data_req    = 1'b1;
        mem_addr_ok = 1'b1;
        #1;
        total_cnt++;
        if ({data_addr_ok, inst_addr_ok} !== 2'b10)
            $display("FAIL prio_addr_ok: got d%b i%b want d1 i0",
                data_addr_ok, inst_addr_ok);
        else pass_cnt++;
        total_cnt++;
        if (mem_addr !== DADDR)
            $display("FAIL prio_mem_addr: got %h want %h", mem_addr, DADDR);
        else pass_cnt++;
        exp_q.push_back(1'b1);
        step();
        idle();
        #1;
        total_cnt++;
        if (outstanding_cnt !== 2'd1)
            $display("FAIL prio_cnt: got %0d want 1", outstanding_cnt);
        else pass_cnt++;
        mem_data_ok = 1'b1;
        mem_rdata   = 32'hCAFE_0001;
        #1;
        e = exp_q.pop_front();
        total_cnt++;
        if ({data_data_ok, inst_data_ok} !== {e, ~e})
            $display("FAIL prio_head: got d%b i%b want d%b i%b",
                data_data_ok, inst_data_ok, e, ~e);
        else pass_cnt++;
        total_cnt++;
        if (data_rdata !== 32'hCAFE_0001)
            $display("FAIL prio_rdata: got %h want cafe0001", data_rdata);
        else pass_cnt++;
        step();
        idle();
    endtask

    task automatic test_lock();
        data_req    = 1'b1;
        mem_addr_ok = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (c == 1) inst_req = 1'b1;
            if (c == 3) mem_addr_ok = 1'b1;
            #1;
            total_cnt++;
            if (data_addr_ok !== (c == 3) || inst_addr_ok !== 1'b0
                || mem_addr !== DADDR)
                $display("FAIL lock_data_c%0d: got d%b i%b a=%h want d%b i0 a=%h",
                    c, data_addr_ok, inst_addr_ok, mem_addr, (c == 3), DADDR);
            else pass_cnt++;
            if (c == 3) exp_q.push_back(1'b1);
            step();
        end
        data_req    = 1'b0;
        mem_addr_ok = 1'b0;
        step();
        data_req = 1'b1;
        #1;
        total_cnt++;
        if (mem_addr !== IADDR || data_addr_ok !== 1'b0)
            $display("FAIL lock_inst_hold: got a=%h d%b want a=%h d0",
                mem_addr, data_addr_ok, IADDR);
        else pass_cnt++;
        step();
        mem_addr_ok = 1'b1;
        #1;
        total_cnt++;
        if ({inst_addr_ok, data_addr_ok} !== 2'b10)
            $display("FAIL lock_inst_grant: got i%b d%b want i1 d0",
                inst_addr_ok, data_addr_ok);
        else pass_cnt++;
        exp_q.push_back(1'b0);
        step();
        idle();
        #1;
        total_cnt++;
        if (outstanding_cnt !== 2'd2)
            $display("FAIL lock_cnt: got %0d want 2", outstanding_cnt);
        else pass_cnt++;
        for (int k = 0; k < 2; k++) begin
            mem_data_ok = 1'b1;
            #1;
            e = exp_q.pop_front();
            total_cnt++;
            if ({data_data_ok, inst_data_ok} !== {e, ~e})
                $display("FAIL lock_resp%0d: got d%b i%b want d%b i%b",
                    k, data_data_ok, inst_data_ok, e, ~e);
            else pass_cnt++;
            step();
        end
        idle();
    endtask

    task automatic test_streak();
        logic exp_d;
        inst_req    = 1'b1;
        data_req    = 1'b1;
        mem_addr_ok = 1'b1;
        for (int k = 0; k < 10; k++) begin
            exp_d       = ((k % 5) != 4);
            mem_data_ok = (k > 0);
            #1;
            total_cnt++;
            if ({data_addr_ok, inst_addr_ok} !== {exp_d, ~exp_d})
                $display("FAIL streak_grant%0d: got d%b i%b want d%b i%b",
                    k, data_addr_ok, inst_addr_ok, exp_d, ~exp_d);
            else pass_cnt++;
            if (k > 0) begin
                e = exp_q.pop_front();
                total_cnt++;
                if ({data_data_ok, inst_data_ok} !== {e, ~e})
                    $display("FAIL streak_resp%0d: got d%b i%b want d%b i%b",
                        k, data_data_ok, inst_data_ok, e, ~e);
                else pass_cnt++;
            end
            exp_q.push_back(exp_d);
            step();
        end
        idle();
        mem_data_ok = 1'b1;
        #1;
        e = exp_q.pop_front();
        total_cnt++;
        if ({data_data_ok, inst_data_ok} !== {e, ~e})
            $display("FAIL streak_last: got d%b i%b want d%b i%b",
                data_data_ok, inst_data_ok, e, ~e);
        else pass_cnt++;
        step();
        idle();
        #1;
        total_cnt++;
        if (outstanding_cnt !== 2'd0)
            $display("FAIL streak_cnt: got %0d want 0", outstanding_cnt);
        else pass_cnt++;
    endtask

    task automatic test_fill_and_respond();
        inst_req    = 1'b1;
        mem_addr_ok = 1'b1;
        #1;
        exp_q.push_back(1'b0);
        step();
        inst_req = 1'b0;
        data_req = 1'b1;
        #1;
        exp_q.push_back(1'b1);
        step();
        data_req = 1'b0;
        inst_req = 1'b1;
        #1;
        total_cnt++;
        if (mem_req !== 1'b0 || inst_addr_ok !== 1'b0
            || outstanding_cnt !== 2'd2)
            $display("FAIL fill_block: got req=%b ok=%b cnt=%0d want 0 0 2",
                mem_req, inst_addr_ok, outstanding_cnt);
        else pass_cnt++;
        step();
        idle();
        mem_data_ok = 1'b1;
        mem_rdata   = 32'h1234_5678;
        #1;
        e = exp_q.pop_front();
        total_cnt++;
        if ({data_data_ok, inst_data_ok} !== {e, ~e}
            || inst_rdata !== 32'h1234_5678)
            $display("FAIL fill_resp0: got d%b i%b r=%h want d%b i%b r=12345678",
                data_data_ok, inst_data_ok, inst_rdata, e, ~e);
        else pass_cnt++;
        step();
        mem_rdata = 32'h9ABC_DEF0;
        #1;
        e = exp_q.pop_front();
        total_cnt++;
        if ({data_data_ok, inst_data_ok} !== {e, ~e}
            || data_rdata !== 32'h9ABC_DEF0)
            $display("FAIL fill_resp1: got d%b i%b r=%h want d%b i%b r=9abcdef0",
                data_data_ok, inst_data_ok, data_rdata, e, ~e);
        else pass_cnt++;
        step();
        idle();
    endtask

    task automatic test_full_pushpop();
        inst_req    = 1'b1;
        mem_addr_ok = 1'b1;
        exp_q.push_back(1'b0);
        step();
        inst_req = 1'b0;
        data_req = 1'b1;
        exp_q.push_back(1'b1);
        step();
        mem_data_ok = 1'b1;
        mem_rdata   = 32'h0000_0055;
        #1;
        e = exp_q.pop_front();
        total_cnt++;
        if (outstanding_cnt !== 2'd2 || mem_req !== 1'b0
            || data_addr_ok !== 1'b0)
            $display("FAIL full_block: got cnt=%0d req=%b ok=%b want 2 0 0",
                outstanding_cnt, mem_req, data_addr_ok);
        else pass_cnt++;
        total_cnt++;
        if ({data_data_ok, inst_data_ok} !== {e, ~e})
            $display("FAIL full_pop: got d%b i%b want d%b i%b",
                data_data_ok, inst_data_ok, e, ~e);
        else pass_cnt++;
        step();
        mem_data_ok = 1'b0;
        #1;
        total_cnt++;
        if (outstanding_cnt !== 2'd1 || data_addr_ok !== 1'b1)
            $display("FAIL full_next: got cnt=%0d ok=%b want 1 1",
                outstanding_cnt, data_addr_ok);
        else pass_cnt++;
        exp_q.push_back(1'b1);
        step();
        idle();
        #1;
        total_cnt++;
        if (outstanding_cnt !== 2'd2)
            $display("FAIL full_refill: got %0d want 2", outstanding_cnt);
        else pass_cnt++;
        for (int k = 0; k < 2; k++) begin
            mem_data_ok = 1'b1;
            #1;
            e = exp_q.pop_front();
            total_cnt++;
            if ({data_data_ok, inst_data_ok} !== {e, ~e})
                $display("FAIL full_drain%0d: got d%b i%b want d%b i%b",
                    k, data_data_ok, inst_data_ok, e, ~e);
            else pass_cnt++;
            step();
        end
        idle();
    endtask

    task automatic test_unexp_resp();
        mem_data_ok = 1'b1;
        #1;
        total_cnt++;
        if ({inst_data_ok, data_data_ok} !== 2'b00)
            $display("FAIL unexp_oks: got i%b d%b want 0 0",
                inst_data_ok, data_data_ok);
        else pass_cnt++;
        step();
        mem_data_ok = 1'b0;
        step();
        total_cnt++;
        if (err_unexp_resp !== 1'b1 || outstanding_cnt !== 2'd0)
            $display("FAIL unexp_err: got err=%b cnt=%0d want 1 0",
                err_unexp_resp, outstanding_cnt);
        else pass_cnt++;
        inst_req    = 1'b1;
        mem_addr_ok = 1'b1;
        step();
        idle();
        total_cnt++;
        if (outstanding_cnt !== 2'd1)
            $display("FAIL unexp_pre_rst_cnt: got %0d want 1",
                outstanding_cnt);
        else pass_cnt++;
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        #1;
        total_cnt++;
        if (err_unexp_resp !== 1'b0 || outstanding_cnt !== 2'd0)
            $display("FAIL unexp_rst: got err=%b cnt=%0d want 0 0",
                err_unexp_resp, outstanding_cnt);
        else pass_cnt++;
        mem_data_ok = 1'b1;
        #1;
        total_cnt++;
        if ({inst_data_ok, data_data_ok} !== 2'b00)
            $display("FAIL stray_oks: got i%b d%b want 0 0",
                inst_data_ok, data_data_ok);
        else pass_cnt++;
        step();
        mem_data_ok = 1'b0;
        #1;
        total_cnt++;
        if (err_unexp_resp !== 1'b1)
            $display("FAIL stray_err: got %b want 1", err_unexp_resp);
        else pass_cnt++;
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        step();
    endtask

    initial begin
        inst_wr    = 1'b0;
        inst_size  = 2'd2;
        inst_addr  = IADDR;
        inst_wstrb = 4'hF;
        inst_wdata = 32'h0;
        data_wr    = 1'b1;
        data_size  = 2'd2;
        data_addr  = DADDR;
        data_wstrb = 4'hF;
        data_wdata = 32'hDEAD_BEEF;
        resetn     = 1'b0;
        idle();
        test_reset();
        test_priority();
        test_lock();
        test_streak();
        test_fill_and_respond();
        test_full_pushpop();
        test_unexp_resp();
        total_cnt++;
        if (exp_q.size() != 0)
            $display("FAIL scoreboard_left: got %0d want 0", exp_q.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
